// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ requesters.
// Grants are held for at most MAX_BURST accepted beats; wfull back-pressures the owner.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       wfull,
  output logic                       winc,
  output logic [WIDTH-1:0]           wdata,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST) + 1;
  localparam logic [IDW-1:0] ID_LAST    = IDW'(NUM_REQ - 1);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_d;
  logic [IDW-1:0]     grant_d, rr_ptr, rr_d, next_id;
  logic [BCW-1:0]     burst_cnt, burst_d;
  logic               beat, exhausted, release_g;
  logic [NUM_REQ-1:0] keep_mask;

  // First valid index scanning from start upward, wrapping at NUM_REQ.
  function automatic logic [IDW-1:0] pick(input logic [NUM_REQ-1:0] vld,
                                          input logic [IDW-1:0]     start);
    logic [IDW-1:0] idx;
    logic [IDW-1:0] res;
    logic           found;
    idx   = start;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && vld[idx]) begin
        res   = idx;
        found = 1'b1;
      end
      idx = (idx == ID_LAST) ? '0 : idx + 1'b1;
    end
    return res;
  endfunction

  always_comb begin
    busy      = (state == GRANT);
    req_ready = '0;
    if (busy && !wfull) req_ready[grant_id] = 1'b1;
    beat  = req_valid[grant_id] & req_ready[grant_id];
    winc  = beat;
    wdata = req_data[grant_id*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_id  <= '0;
      burst_cnt <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_d;
      grant_id  <= grant_d;
      burst_cnt <= burst_d;
      rr_ptr    <= rr_d;
    end
  end

  always_comb begin
    state_d   = state;
    grant_d   = grant_id;
    burst_d   = burst_cnt;
    rr_d      = rr_ptr;
    next_id   = (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;
    exhausted = beat && (burst_cnt == BURST_LAST);
    release_g = exhausted || !req_valid[grant_id];
    // An exhausted owner only comes back through IDLE when nobody else wants the port.
    keep_mask = req_valid;
    if (exhausted) keep_mask[grant_id] = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_d = pick(req_valid, rr_ptr);
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_g) begin
          rr_d = next_id;
          if (|keep_mask) begin
            grant_d = pick(req_valid, next_id);
            burst_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (beat) begin
          burst_d = burst_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: single requester, rotation, full stall,
// early hand-over with wrap, and asynchronous reset mid-beat.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     wfull;
  logic                     winc;
  logic [WIDTH-1:0]         wdata;
  logic [1:0]               grant_id;
  logic                     busy;

  logic [7:0] d [NUM_REQ];
  int n_tests = 0;
  int n_fail  = 0;

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = d[i];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1_mask;
    logic [7:0] cnt [NUM_REQ];
    int beats;
    int g;

    rst = 1'b1;
    req_valid = '0;
    wfull = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) d[i] = 8'h55;
    #3;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_gid", 32'(grant_id), 32'(0));
    chk("rst_winc", 32'(winc), 32'(0));
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_rr", 32'(dut.rr_ptr), 32'(0));
    chk("rst_bcnt", 32'(dut.burst_cnt), 32'(0));
    tick();
    rst = 1'b0;
    tick();

    // Single requester 2: A0..A3, one IDLE bubble, re-grant for A4..A5.
    t1_mask = 8'b1101_1110;
    req_valid = 4'b0100;
    beats = 0;
    for (int c = 0; c < 8; c++) begin
      d[2] = 8'hA0 + 8'(beats);
      #1;
      chk("t1_winc", 32'(winc), 32'(t1_mask[c]));
      chk("t1_busy", 32'(busy), 32'(t1_mask[c]));
      if (t1_mask[c]) begin
        chk("t1_gid", 32'(grant_id), 32'(2));
        chk("t1_wdata", 32'(wdata), 32'(8'hA0 + 8'(beats)));
        beats++;
      end
      tick();
    end
    req_valid = 4'b0000;
    #1;
    chk("t1_drop_busy", 32'(busy), 32'(1));
    chk("t1_drop_winc", 32'(winc), 32'(0));
    tick();
    chk("t1_idle_busy", 32'(busy), 32'(0));

    // Fair rotation from a fresh reset: 0x4, 1x4, 2x4, 3x4, 0x4.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt[i] = '0;
      d[i]   = 8'(16 * i);
    end
    req_valid = 4'b1111;
    #1;
    chk("t2_first_winc", 32'(winc), 32'(0));
    tick();
    for (int k = 0; k < 20; k++) begin
      g = (k / 4) % 4;
      for (int i = 0; i < NUM_REQ; i++) d[i] = 8'(16 * i) + cnt[i];
      #1;
      chk("t2_winc", 32'(winc), 32'(1));
      chk("t2_gid", 32'(grant_id), 32'(g));
      chk("t2_wdata", 32'(wdata), 32'(8'(16 * g) + cnt[g]));
      chk("t2_ready", 32'(req_ready), 32'(4'b0001 << g));
      cnt[g] = cnt[g] + 8'd1;
      tick();
    end
    req_valid = 4'b0000;
    tick();
    chk("t2_idle_busy", 32'(busy), 32'(0));

    // Full stall on requester 1 after two beats; two more beats then release.
    req_valid = 4'b0010;
    d[1] = 8'hB0;
    #1;
    chk("t3_idle_winc", 32'(winc), 32'(0));
    tick();
    for (int b = 0; b < 2; b++) begin
      d[1] = 8'hB0 + 8'(b);
      #1;
      chk("t3_gid", 32'(grant_id), 32'(1));
      chk("t3_wdata", 32'(wdata), 32'(8'hB0 + 8'(b)));
      chk("t3_winc", 32'(winc), 32'(1));
      tick();
    end
    d[1] = 8'hB2;
    wfull = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("t3_stall_winc", 32'(winc), 32'(0));
      chk("t3_stall_ready", 32'(req_ready), 32'(0));
      chk("t3_stall_bcnt", 32'(dut.burst_cnt), 32'(2));
      chk("t3_stall_busy", 32'(busy), 32'(1));
      tick();
    end
    wfull = 1'b0;
    for (int b = 2; b < 4; b++) begin
      d[1] = 8'hB0 + 8'(b);
      #1;
      chk("t3_winc", 32'(winc), 32'(1));
      chk("t3_wdata", 32'(wdata), 32'(8'hB0 + 8'(b)));
      tick();
    end
    req_valid = 4'b0000;
    #1;
    chk("t3_release_busy", 32'(busy), 32'(0));
    chk("t3_release_winc", 32'(winc), 32'(0));
    tick();

    // Requester 3 drops after one beat; hand-over to 0 with no bubble.
    d[3] = 8'hC3;
    d[0] = 8'hD0;
    req_valid = 4'b1000;
    tick();
    #1;
    chk("t4_gid3", 32'(grant_id), 32'(3));
    chk("t4_winc3", 32'(winc), 32'(1));
    chk("t4_wdata3", 32'(wdata), 32'(8'hC3));
    tick();
    req_valid = 4'b0001;
    #1;
    chk("t4_hold_gid", 32'(grant_id), 32'(3));
    chk("t4_hold_winc", 32'(winc), 32'(0));
    tick();
    chk("t4_busy0", 32'(busy), 32'(1));
    chk("t4_gid0", 32'(grant_id), 32'(0));
    chk("t4_winc0", 32'(winc), 32'(1));
    chk("t4_wdata0", 32'(wdata), 32'(8'hD0));
    chk("t4_rr", 32'(dut.rr_ptr), 32'(0));
    tick();

    // Hand to requester 1 (rr_ptr becomes 1), then reset asynchronously mid-beat.
    req_valid = 4'b0010;
    #1;
    chk("t5_hand_winc", 32'(winc), 32'(0));
    tick();
    #1;
    chk("t5_gid1", 32'(grant_id), 32'(1));
    chk("t5_winc1", 32'(winc), 32'(1));
    chk("t5_rr1", 32'(dut.rr_ptr), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_winc", 32'(winc), 32'(0));
    chk("t5_rst_busy", 32'(busy), 32'(0));
    chk("t5_rst_ready", 32'(req_ready), 32'(0));
    tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) d[i] = 8'hE0 + 8'(i);
    #1;
    chk("t5_post_busy", 32'(busy), 32'(0));
    chk("t5_post_rr", 32'(dut.rr_ptr), 32'(0));
    tick();
    #1;
    chk("t5_regrant_busy", 32'(busy), 32'(1));
    chk("t5_regrant_gid", 32'(grant_id), 32'(0));
    chk("t5_regrant_winc", 32'(winc), 32'(1));
    chk("t5_regrant_wdata", 32'(wdata), 32'(8'hE0));
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
